camera_frame_capture: RTL and testbench

Captures one frame from the camera 1 parallel interface (FV, LV, 12-bit pixel) and streams it as 8-bit pixel bytes to the flash-write path. Sits directly downstream of the camera pins, in the pixel-clock domain, and feeds the flash writer through a valid/ready handshake backed by a small internal FIFO. Capture is armed by a single-cycle command and completes with a done pulse plus frame statistics.

---
 rtl/cam_capture_pkg.sv | 21 ++
 rtl/cam_byte_fifo.sv | 62 ++++++
 rtl/camera_frame_capture.sv | 153 +++++++++++++++
 tb/tb_camera_frame_capture.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera frame capture block.
package cam_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FV_LOW,
    ST_WAIT_FV_RISE,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  localparam int BYTE_W  = 8;
  localparam int PIX_W   = 12;
  localparam int PIX_MSB = 11;
  localparam int PIX_LSB = 4;

  function automatic logic [BYTE_W-1:0] pix_to_byte(input logic [PIX_W-1:0] pix);
    return pix[PIX_MSB:PIX_LSB];
  endfunction

endpackage

// File: rtl/cam_byte_fifo.sv
// First-word-fall-through byte FIFO with count-based full/empty and synchronous flush.
// A write on a full FIFO is accepted only when a read frees a slot in the same cycle.
module cam_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_wr_vld,
  input  logic [W-1:0]           i_wr_dat,
  output logic                   o_wr_drop,
  output logic                   o_rd_vld,
  output logic [W-1:0]           o_rd_dat,
  input  logic                   i_rd_rdy,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_rd_fire;
  logic          w_wr_fire;

  assign w_full    = (r_count == FULL_CNT);
  assign o_rd_vld  = (r_count != '0);
  assign w_rd_fire = o_rd_vld & i_rd_rdy;
  assign w_wr_fire = i_wr_vld & (~w_full | w_rd_fire);
  assign o_wr_drop = i_wr_vld & w_full & ~w_rd_fire;
  // Gate the head so the output reads zero whenever nothing is held.
  assign o_rd_dat  = o_rd_vld ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_wr_fire && !i_flush) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/camera_frame_capture.sv
// Captures one armed frame from the camera 1 parallel port and streams pixel[11:4] bytes out.
// Pins -> S1 register -> write stage -> FWFT FIFO; done fires when the frame is fully drained.
module camera_frame_capture
  import cam_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_CNT_W  = 12,
  parameter int LINE_CNT_W = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  camera_1_FV,
  input  logic                  camera_1_LV,
  input  logic [PIX_W-1:0]      camera_1_pixel_in,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic [PIX_CNT_W-1:0]  last_line_pixels
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_fv_s1;
  logic                  r_lv_s1;
  logic                  r_fv_prev;
  logic [PIX_W-1:0]      r_pix_s1;
  logic                  r_wr_vld;
  logic [BYTE_W-1:0]     r_wr_dat;
  logic                  r_line_open;
  logic [PIX_CNT_W-1:0]  r_pix_cnt;
  logic [PIX_CNT_W-1:0]  r_last_pix;
  logic [LINE_CNT_W-1:0] r_line_cnt;
  logic                  r_overflow;
  logic                  r_done;
  logic [PIX_CNT_W-1:0]  w_pix_base;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_drop;
  logic                  w_rd_fire;
  logic                  w_arm_ok;
  logic                  w_done;
  logic                  w_pix_take;
  logic                  w_line_close;
  logic                  w_drain_empty;

  cam_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_flush   (abort),
    .i_wr_vld  (r_wr_vld),
    .i_wr_dat  (r_wr_dat),
    .o_wr_drop (w_fifo_drop),
    .o_rd_vld  (out_valid),
    .o_rd_dat  (out_data),
    .i_rd_rdy  (out_ready),
    .o_count   (w_fifo_count)
  );

  assign w_rd_fire     = out_valid & out_ready;
  // Look one handshake ahead so done lands the cycle right after the last byte leaves.
  assign w_drain_empty = ~r_wr_vld &
                         ((w_fifo_count == '0) || ((w_fifo_count == CW'(1)) && w_rd_fire));
  assign w_pix_take    = (r_state == ST_CAPTURE) & r_fv_s1 & r_lv_s1;
  assign w_line_close  = (r_state == ST_CAPTURE) & r_line_open & ~(r_fv_s1 & r_lv_s1);
  assign w_pix_base    = r_line_open ? r_pix_cnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_ok    = 1'b0;
    w_done      = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (arm) begin
          w_arm_ok    = 1'b1;
          w_state_nxt = r_fv_s1 ? ST_WAIT_FV_LOW : ST_WAIT_FV_RISE;
        end
        ST_WAIT_FV_LOW:  if (!r_fv_s1) w_state_nxt = ST_WAIT_FV_RISE;
        ST_WAIT_FV_RISE: if (r_fv_s1 && !r_fv_prev) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE:      if (!r_fv_s1) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_drain_empty) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fv_s1     <= 1'b0;
      r_lv_s1     <= 1'b0;
      r_fv_prev   <= 1'b0;
      r_pix_s1    <= '0;
      r_wr_vld    <= 1'b0;
      r_wr_dat    <= '0;
      r_line_open <= 1'b0;
      r_pix_cnt   <= '0;
      r_last_pix  <= '0;
      r_line_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fv_s1   <= camera_1_FV;
      r_lv_s1   <= camera_1_LV;
      r_pix_s1  <= camera_1_pixel_in;
      r_fv_prev <= r_fv_s1;
      r_done    <= w_done;
      r_wr_vld  <= w_pix_take & ~abort;
      r_wr_dat  <= pix_to_byte(r_pix_s1);
      if (abort) begin
        r_line_open <= 1'b0;
      end else if (w_arm_ok) begin
        r_overflow  <= 1'b0;
        r_line_cnt  <= '0;
        r_last_pix  <= '0;
        r_pix_cnt   <= '0;
        r_line_open <= 1'b0;
      end else begin
        if (w_fifo_drop) r_overflow <= 1'b1;
        // Dropped pixels still count: the counter reflects the camera line, not FIFO success.
        if (w_pix_take) begin
          r_line_open <= 1'b1;
          r_pix_cnt   <= (&w_pix_base) ? w_pix_base : w_pix_base + PIX_CNT_W'(1);
        end else if (w_line_close) begin
          r_line_open <= 1'b0;
          r_last_pix  <= r_pix_cnt;
          r_line_cnt  <= (&r_line_cnt) ? r_line_cnt : r_line_cnt + LINE_CNT_W'(1);
        end
      end
    end
  end

  assign busy             = (r_state != ST_IDLE);
  assign done             = r_done;
  assign overflow         = r_overflow;
  assign line_count       = r_line_cnt;
  assign last_line_pixels = r_last_pix;

endmodule

// File: tb/tb_camera_frame_capture.sv
// Scoreboard bench for camera_frame_capture: pixel ramps in, expected bytes queued, output popped and compared.
module tb_camera_frame_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic        fv;
  logic        lv;
  logic [11:0] pix;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [10:0] line_count;
  logic [11:0] last_line_pixels;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rx_cnt   = 0;
  int          done_cnt = 0;
  logic [7:0]  sb [$];
  logic [11:0] pix_val  = 12'h000;
  bit          tog_en   = 1'b0;
  bit          lat_chk  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_dat = 8'h00;

  always #5 clk = ~clk;

  camera_frame_capture #(.FIFO_DEPTH(16), .PIX_CNT_W(12), .LINE_CNT_W(11)) dut (
    .clk               (clk),
    .reset             (reset),
    .arm               (arm),
    .abort             (abort),
    .camera_1_FV       (fv),
    .camera_1_LV       (lv),
    .camera_1_pixel_in (pix),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .line_count        (line_count),
    .last_line_pixels  (last_line_pixels)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // One clock: observe at the falling edge, then step past the rising edge and update inputs.
  task automatic tick();
    logic [7:0] exp;
    @(negedge clk);
    if (done) done_cnt++;
    if (prev_stall && out_valid) begin
      n_checks++;
      if (out_data !== prev_dat) $display("FAIL hold: out_data=%h required %h", out_data, prev_dat);
      else n_pass++;
    end
    if (out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL byte_unexpected: out_data=%h required no byte", out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) $display("FAIL byte: out_data=%h required %h", out_data, exp);
        else n_pass++;
      end
      rx_cnt++;
    end
    prev_stall = out_valid && !out_ready;
    prev_dat   = out_data;
    @(posedge clk);
    #1;
    if (tog_en) out_ready = ~out_ready;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drive_frame(input int lines, input int ppl, input int blank,
                             input int n_expect, input bit keep_fv);
    int pushed = 0;
    fv = 1'b1;
    repeat (4) tick();
    for (int l = 0; l < lines; l++) begin
      lv = 1'b1;
      for (int p = 0; p < ppl; p++) begin
        pix = pix_val;
        if (pushed < n_expect) sb.push_back(pix_val[11:4]);
        pushed++;
        tick();
        if (lat_chk && l == 0 && p == 1) begin
          n_checks++;
          if (out_valid !== 1'b0) $display("FAIL latency_n1: out_valid=%b required 0", out_valid);
          else n_pass++;
        end
        if (lat_chk && l == 0 && p == 2) begin
          n_checks++;
          if (out_valid !== 1'b1) $display("FAIL latency_n2: out_valid=%b required 1", out_valid);
          else n_pass++;
        end
        pix_val += 12'h010;
      end
      lv  = 1'b0;
      pix = 12'h000;
      repeat (blank) tick();
    end
    if (!keep_fv) begin
      fv = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic wait_done(input int budget, input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (done_cnt == d0) $display("FAIL %s_done_timeout: done pulses=0 required 1 within %0d cycles", name, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [34:0] snap;
    reset = 1'b0; arm = 1'b0; abort = 1'b0;
    fv = 1'b0; lv = 1'b0; pix = 12'h000; out_ready = 1'b0;
    repeat (3) tick();
    snap = {out_data, out_valid, busy, done, overflow, line_count, last_line_pixels};
    n_checks++;
    if (snap !== '0) $display("FAIL reset_hold: outputs=%h required 0", snap);
    else n_pass++;
    reset = 1'b1;
    repeat (2) tick();
    snap = {out_data, out_valid, busy, done, overflow, line_count, last_line_pixels};
    n_checks++;
    if (snap !== '0) $display("FAIL reset_release: outputs=%h required 0", snap);
    else n_pass++;
  endtask

  task automatic test_basic();
    int rx0 = rx_cnt;
    int d0  = done_cnt;
    out_ready = 1'b1;
    pulse_arm();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_rise: busy=%b required 1", busy);
    else n_pass++;
    lat_chk = 1'b1;
    drive_frame(5, 40, 10, 200, 1'b0);
    lat_chk = 1'b0;
    wait_done(100, d0, "basic");
    repeat (3) tick();
    n_checks++;
    if (rx_cnt - rx0 !== 200) $display("FAIL basic_bytes: got %0d required 200", rx_cnt - rx0);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL basic_sb_left: got %0d required 0", sb.size());
    else n_pass++;
    n_checks++;
    if (line_count !== 11'd5) $display("FAIL basic_line_count: got %0d required 5", line_count);
    else n_pass++;
    n_checks++;
    if (last_line_pixels !== 12'd40) $display("FAIL basic_last_pixels: got %0d required 40", last_line_pixels);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b required 0", overflow);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_fall: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_arm_midframe();
    int rx0 = rx_cnt;
    int d0  = done_cnt;
    out_ready = 1'b1;
    fv = 1'b1;
    repeat (3) tick();
    pulse_arm();
    drive_frame(5, 40, 10, 0, 1'b0);
    drive_frame(5, 40, 10, 200, 1'b0);
    wait_done(100, d0, "midframe");
    repeat (3) tick();
    n_checks++;
    if (rx_cnt - rx0 !== 200) $display("FAIL midframe_bytes: got %0d required 200", rx_cnt - rx0);
    else n_pass++;
    n_checks++;
    if (line_count !== 11'd5) $display("FAIL midframe_line_count: got %0d required 5", line_count);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL midframe_done_count: got %0d required 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int rx0 = rx_cnt;
    int d0  = done_cnt;
    out_ready = 1'b0;
    pulse_arm();
    drive_frame(1, 40, 10, 16, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b required 1", out_valid);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL stall_overflow: got %b required 1", overflow);
    else n_pass++;
    n_checks++;
    if (last_line_pixels !== 12'd40) $display("FAIL stall_last_pixels: got %0d required 40", last_line_pixels);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b1) $display("FAIL stall_early_done: done=%0d busy=%b required 0/1", done_cnt - d0, busy);
    else n_pass++;
    out_ready = 1'b1;
    wait_done(60, d0, "stall");
    repeat (3) tick();
    n_checks++;
    if (rx_cnt - rx0 !== 16) $display("FAIL stall_bytes: got %0d required 16", rx_cnt - rx0);
    else n_pass++;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL stall_sb_left: got %0d required 0", sb.size());
    else n_pass++;
  endtask

  // Half-rate reads: 24-pixel lines keep the peak FIFO fill below 16 entries.
  task automatic test_toggle();
    int rx0 = rx_cnt;
    int d0  = done_cnt;
    out_ready = 1'b1;
    tog_en = 1'b1;
    pulse_arm();
    drive_frame(5, 24, 30, 120, 1'b0);
    wait_done(100, d0, "toggle");
    tog_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rx_cnt - rx0 !== 120) $display("FAIL toggle_bytes: got %0d required 120", rx_cnt - rx0);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL toggle_overflow: got %b required 0", overflow);
    else n_pass++;
    n_checks++;
    if (line_count !== 11'd5 || last_line_pixels !== 12'd24)
      $display("FAIL toggle_stats: lines=%0d pixels=%0d required 5/24", line_count, last_line_pixels);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL toggle_done_count: got %0d required 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_abort();
    int rx0 = rx_cnt;
    int d0  = done_cnt;
    out_ready = 1'b1;
    pulse_arm();
    drive_frame(2, 40, 10, 80, 1'b1);
    out_ready = 1'b0;
    lv = 1'b1;
    for (int p = 0; p < 10; p++) begin
      pix = pix_val;
      pix_val += 12'h010;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_outputs: valid=%b busy=%b required 0/0", out_valid, busy);
    else n_pass++;
    lv = 1'b0; fv = 1'b0; pix = 12'h000;
    repeat (10) tick();
    n_checks++;
    if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: got %0d required 0", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (rx_cnt - rx0 !== 80) $display("FAIL abort_bytes: got %0d required 80", rx_cnt - rx0);
    else n_pass++;
    out_ready = 1'b1;
    pulse_arm();
    drive_frame(5, 40, 10, 200, 1'b0);
    wait_done(100, d0, "abort_recap");
    repeat (3) tick();
    n_checks++;
    if (line_count !== 11'd5 || overflow !== 1'b0)
      $display("FAIL abort_recap_stats: lines=%0d overflow=%b required 5/0", line_count, overflow);
    else n_pass++;
    n_checks++;
    if (rx_cnt - rx0 !== 280 || sb.size() !== 0)
      $display("FAIL abort_recap_bytes: got %0d left %0d required 280/0", rx_cnt - rx0, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [34:0] snap;
    int rx0 = rx_cnt;
    int d0  = done_cnt;
    out_ready = 1'b0;
    pulse_arm();
    drive_frame(1, 20, 5, 0, 1'b1);
    lv = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pix = pix_val;
      pix_val += 12'h010;
      tick();
    end
    n_checks++;
    if (overflow !== 1'b1 || last_line_pixels !== 12'd20 || out_valid !== 1'b1)
      $display("FAIL rstmid_pre: overflow=%b pixels=%0d valid=%b required 1/20/1", overflow, last_line_pixels, out_valid);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    snap = {out_data, out_valid, busy, done, overflow, line_count, last_line_pixels};
    n_checks++;
    if (snap !== '0) $display("FAIL rstmid_async: outputs=%h required 0", snap);
    else n_pass++;
    lv = 1'b0; fv = 1'b0; pix = 12'h000;
    repeat (2) tick();
    reset = 1'b1;
    out_ready = 1'b1;
    drive_frame(1, 10, 5, 0, 1'b0);
    n_checks++;
    if (busy !== 1'b0 || rx_cnt - rx0 !== 0 || done_cnt - d0 !== 0)
      $display("FAIL rstmid_no_rearm: busy=%b bytes=%0d done=%0d required 0/0/0", busy, rx_cnt - rx0, done_cnt - d0);
    else n_pass++;
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL arm_abort_busy: busy=%b required 0", busy);
    else n_pass++;
    drive_frame(1, 10, 5, 0, 1'b0);
    n_checks++;
    if (busy !== 1'b0 || rx_cnt - rx0 !== 0) $display("FAIL arm_abort_idle: busy=%b bytes=%0d required 0/0", busy, rx_cnt - rx0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arm_midframe();
    test_stall();
    test_toggle();
    test_abort();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
